rx_fifo_arbiter: RTL and testbench

Round-robin read arbiter that merges up to N fei4_rx channel FIFOs into the single show-ahead read port of the output bram_fifo. It sits between the rx_gen receiver instances and i_out_fifo, in the BUS_CLK domain. It grants one non-empty, enabled channel at a time and forwards that channel's data and empty flag. It releases the grant on empty, on burst limit or on disable, so a busy channel cannot starve the others.

---
 rtl/rx_fifo_arbiter_pkg.sv | 18 +
 rtl/rx_fifo_arbiter_if.sv | 29 ++
 rtl/rx_arb_rr_pick.sv | 32 +++
 rtl/rx_fifo_arbiter.sv | 138 +++++++++++++
 tb/tb_rx_fifo_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_fifo_arbiter_pkg.sv
// Shared FSM encoding and counter widths for the rx_fifo_arbiter block.
// Imported by the interface, the round-robin picker and the arbiter top.
package rx_fifo_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arbState_e;

  localparam int BURST_CNT_W = 8;
  localparam int STATS_CNT_W = 16;

  // Saturating increment for the per-channel statistics counters
  function automatic logic [STATS_CNT_W-1:0] satInc(input logic [STATS_CNT_W-1:0] value);
    return (&value) ? value : value + STATS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_fifo_arbiter_if.sv
// Channel-side and output-FIFO-side signals of the rx_fifo_arbiter.
// master = arbiter view, slave = receiver/bram_fifo view.
interface rx_fifo_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int DWIDTH = 32
);
  import rx_fifo_arbiter_pkg::*;

  logic [N_CH-1:0]             CH_ENABLE;
  logic [N_CH-1:0]             CH_EMPTY;
  logic [N_CH*DWIDTH-1:0]      CH_DATA;
  logic [N_CH-1:0]             CH_READ;
  logic                        OUT_READ;
  logic                        OUT_EMPTY;
  logic [DWIDTH-1:0]           OUT_DATA;
  logic [N_CH-1:0]             GRANT;
  logic [N_CH*STATS_CNT_W-1:0] GRANT_CNT;

  modport master (
    input  CH_ENABLE, CH_EMPTY, CH_DATA, OUT_READ,
    output CH_READ, OUT_EMPTY, OUT_DATA, GRANT, GRANT_CNT
  );

  modport slave (
    output CH_ENABLE, CH_EMPTY, CH_DATA, OUT_READ,
    input  CH_READ, OUT_EMPTY, OUT_DATA, GRANT, GRANT_CNT
  );

endinterface

// File: rtl/rx_arb_rr_pick.sv
// Combinational wrap-around priority picker: first set bit of req_i
// searching upward from last_i+1, returned one-hot.
module rx_arb_rr_pick #(
  parameter int N_CH = 4,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_CH-1:0]  pick_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Offset 1..N_CH from the previous winner; offset N_CH lands on last_i itself
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = IDX_W'((int'(last_i) + i) % N_CH);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin read arbiter merging N_CH show-ahead channel FIFOs into one read port.
// Optional per-channel accepted-read statistics are built when ARB_STATS_EN is defined.
module rx_fifo_arbiter
  import rx_fifo_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  rx_fifo_arbiter_if.master bus
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]       LAST_RST    = IDX_W'(N_CH - 1);

  arbState_e              state_q, state_d;
  logic [N_CH-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;

  logic [N_CH-1:0]        req;
  logic [N_CH-1:0]        pick;
  logic                   pickValid;
  logic [IDX_W-1:0]       pickIdx;
  logic                   grantEnabled;
  logic                   outEmpty;
  logic                   accept;
  logic [N_CH-1:0]        chRead;
  logic [DWIDTH-1:0]      outData;

  assign req = ~bus.CH_EMPTY & bus.CH_ENABLE;

  rx_arb_rr_pick #(.N_CH(N_CH)) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pickValid)
  );

  always_comb begin
    pickIdx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (pick[k]) pickIdx = IDX_W'(k);
    end
  end

  // grant_q is zero whenever the FSM is idle, so the muxes below give the idle outputs for free
  always_comb begin
    outData = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_q[k]) outData = bus.CH_DATA[k*DWIDTH +: DWIDTH];
    end
  end

  assign grantEnabled = |(grant_q & bus.CH_ENABLE);
  assign outEmpty     = ~|(grant_q & req);
  assign accept       = bus.OUT_READ & ~outEmpty;
  assign chRead       = accept ? grant_q : '0;

  assign bus.OUT_DATA  = outData;
  assign bus.OUT_EMPTY = outEmpty;
  assign bus.CH_READ   = chRead;
  assign bus.GRANT     = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      ARB_IDLE: begin
        if (pickValid) begin
          state_d = ARB_BUSY;
          grant_d = pick;
          last_d  = pickIdx;
          burst_d = '0;
        end
      end
      ARB_BUSY: begin
        if (accept) burst_d = burst_q + BURST_CNT_W'(1);
        // All release causes fold into a single return to idle
        if ((accept && (burst_q + BURST_CNT_W'(1) == BURST_LIMIT)) ||
            (outEmpty && !accept) || !grantEnabled) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STATS_CNT_W-1:0]      statsCnt_q [N_CH];
  logic [STATS_CNT_W-1:0]      statsCnt_d [N_CH];
  logic [N_CH*STATS_CNT_W-1:0] grantCnt;

  always_comb begin
    grantCnt = '0;
    for (int k = 0; k < N_CH; k++) begin
      statsCnt_d[k] = chRead[k] ? satInc(statsCnt_q[k]) : statsCnt_q[k];
      grantCnt[k*STATS_CNT_W +: STATS_CNT_W] = statsCnt_q[k];
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      for (int k = 0; k < N_CH; k++) statsCnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) statsCnt_q[k] <= statsCnt_d[k];
    end
  end

  assign bus.GRANT_CNT = grantCnt;
`else
  assign bus.GRANT_CNT = '0;
`endif

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Self-checking bench for rx_fifo_arbiter: a per-cycle vector table, then
// show-ahead channel FIFO models feeding a word/grant-order scoreboard.
module tb_rx_fifo_arbiter;
  import rx_fifo_arbiter_pkg::*;

  localparam int N_CH      = 4;
  localparam int DWIDTH    = 32;
  localparam int MAX_BURST = 16;
  localparam int N_VEC     = 13;

  typedef logic [DWIDTH-1:0] word_t;

  typedef struct {
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] empty;
    logic            rd;
    logic [N_CH-1:0] expGrant;
    logic [N_CH-1:0] expChRead;
    logic            expOutEmpty;
  } vec_t;

  logic clock;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  vec_t            vecs [N_VEC];
  word_t           chQ [N_CH][$];
  word_t           expQ [$];
  int              expGrantQ [$];
  int              expCnt [N_CH];
  int              readCount [N_CH];
  logic [N_CH-1:0] chEnable;
  logic            outRead;
  logic [N_CH-1:0] prevGrant;
  int              busyCycles;
  int              wordsOut;
  int              disableCh;
  int              disableAfter;

  rx_fifo_arbiter_if #(.N_CH(N_CH), .DWIDTH(DWIDTH)) bus ();

  rx_fifo_arbiter #(.N_CH(N_CH), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .BUS_CLK (clock),
    .BUS_RST (reset),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic word_t mkWord(input int ch, input int idx);
    return {4'hC, ch[3:0], idx[23:0]};
  endfunction

  function automatic word_t tablePattern(input int ch);
    return 32'hDA7A_0000 | word_t'(ch);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string msg);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] en, input logic [N_CH-1:0] empty, input logic rd);
    bus.CH_ENABLE = en;
    bus.CH_EMPTY  = empty;
    bus.OUT_READ  = rd;
    for (int k = 0; k < N_CH; k++) bus.CH_DATA[k*DWIDTH +: DWIDTH] = tablePattern(k);
  endtask

  task automatic driveFromModel();
    for (int k = 0; k < N_CH; k++) begin
      bus.CH_EMPTY[k] = (chQ[k].size() == 0);
      if (chQ[k].size() == 0) bus.CH_DATA[k*DWIDTH +: DWIDTH] = '0;
      else                    bus.CH_DATA[k*DWIDTH +: DWIDTH] = chQ[k][0];
    end
    bus.CH_ENABLE = chEnable;
    bus.OUT_READ  = outRead;
  endtask

  task automatic checkStats(input string name);
    for (int k = 0; k < N_CH; k++) begin
`ifdef ARB_STATS_EN
      checkOutput(name, bus.GRANT_CNT[k*16 +: 16], 64'(expCnt[k]));
`else
      checkOutput(name, bus.GRANT_CNT[k*16 +: 16], 64'd0);
`endif
    end
  endtask

  // One clock of the FIFO-model world; entered and left at posedge+1
  task automatic modelCycle();
    logic [N_CH-1:0] g;
    logic [N_CH-1:0] rd;
    logic            acc;
    word_t           w;
    int              e;
    driveFromModel();
    #4;
    g   = bus.GRANT;
    rd  = bus.CH_READ;
    acc = bus.OUT_READ && !bus.OUT_EMPTY;
    if (g != '0) busyCycles++;
    if (g != '0 && g != prevGrant) begin
      if (prevGrant != '0) failNote("idleGap", $sformatf("grant %b followed %b directly", g, prevGrant));
      else if (expGrantQ.size() == 0) failNote("unexpectedGrant", $sformatf("grant %b", g));
      else begin
        e = expGrantQ.pop_front();
        checkOutput("grantOrder", 64'(g), 64'(1) << e);
      end
    end
    prevGrant = g;
    if (acc) begin
      wordsOut++;
      if (expQ.size() == 0) failNote("unexpectedWord", $sformatf("data %0h", bus.OUT_DATA));
      else begin
        w = expQ.pop_front();
        checkOutput("outData", 64'(bus.OUT_DATA), 64'(w));
        checkOutput("chRead", 64'(rd), 64'(1) << int'(w[27:24]));
        expCnt[int'(w[27:24])]++;
      end
    end else begin
      checkOutput("chReadIdle", 64'(rd), 64'd0);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (rd[k]) begin
        if (chQ[k].size() == 0) failNote("readEmptyChannel", $sformatf("channel %0d", k));
        else begin
          void'(chQ[k].pop_front());
          readCount[k]++;
        end
      end
    end
    if (disableCh >= 0 && readCount[disableCh] == disableAfter) chEnable[disableCh] = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic runUntilDrained(input string name, input int budget);
    int cyc = 0;
    while (!(expQ.size() == 0 && bus.GRANT == '0) && cyc < budget) begin
      modelCycle();
      cyc++;
    end
    if (cyc >= budget) failNote(name, "timeout waiting for scoreboard to drain");
    checkOutput({name, "Grants"}, 64'(expGrantQ.size()), 64'd0);
  endtask

  initial begin
    logic [N_CH-1:0] g;
    int              gi;
    int              n;

    vecs[0]  = '{en: 4'b1111, empty: 4'b0000, rd: 1'b0, expGrant: 4'b0000, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[1]  = '{en: 4'b1111, empty: 4'b0000, rd: 1'b0, expGrant: 4'b0001, expChRead: 4'b0000, expOutEmpty: 1'b0};
    vecs[2]  = '{en: 4'b1111, empty: 4'b0000, rd: 1'b1, expGrant: 4'b0001, expChRead: 4'b0001, expOutEmpty: 1'b0};
    vecs[3]  = '{en: 4'b1111, empty: 4'b0001, rd: 1'b1, expGrant: 4'b0001, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[4]  = '{en: 4'b1111, empty: 4'b0001, rd: 1'b1, expGrant: 4'b0000, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[5]  = '{en: 4'b1111, empty: 4'b0001, rd: 1'b1, expGrant: 4'b0010, expChRead: 4'b0010, expOutEmpty: 1'b0};
    vecs[6]  = '{en: 4'b1101, empty: 4'b0001, rd: 1'b1, expGrant: 4'b0010, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[7]  = '{en: 4'b1101, empty: 4'b0001, rd: 1'b0, expGrant: 4'b0000, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[8]  = '{en: 4'b1101, empty: 4'b0001, rd: 1'b0, expGrant: 4'b0100, expChRead: 4'b0000, expOutEmpty: 1'b0};
    vecs[9]  = '{en: 4'b1101, empty: 4'b1111, rd: 1'b1, expGrant: 4'b0100, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[10] = '{en: 4'b1101, empty: 4'b1111, rd: 1'b1, expGrant: 4'b0000, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[11] = '{en: 4'b1111, empty: 4'b1110, rd: 1'b0, expGrant: 4'b0000, expChRead: 4'b0000, expOutEmpty: 1'b1};
    vecs[12] = '{en: 4'b1111, empty: 4'b1110, rd: 1'b0, expGrant: 4'b0001, expChRead: 4'b0000, expOutEmpty: 1'b0};

    for (int k = 0; k < N_CH; k++) begin
      expCnt[k]    = 0;
      readCount[k] = 0;
    end
    prevGrant    = '0;
    busyCycles   = 0;
    wordsOut     = 0;
    disableCh    = -1;
    disableAfter = 0;
    chEnable     = '1;
    outRead      = 1'b0;

    // Reset with every channel requesting
    reset = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstGrant", 64'(bus.GRANT), 64'd0);
    checkOutput("rstOutEmpty", 64'(bus.OUT_EMPTY), 64'd1);
    checkOutput("rstChRead", 64'(bus.CH_READ), 64'd0);
    checkOutput("rstOutData", 64'(bus.OUT_DATA), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < N_VEC; v++) begin
      applyStimulus(vecs[v].en, vecs[v].empty, vecs[v].rd);
      #4;
      g  = vecs[v].expGrant;
      gi = 0;
      for (int k = 0; k < N_CH; k++) if (g[k]) gi = k;
      checkOutput($sformatf("vec%0dGrant", v), 64'(bus.GRANT), 64'(g));
      checkOutput($sformatf("vec%0dChRead", v), 64'(bus.CH_READ), 64'(vecs[v].expChRead));
      checkOutput($sformatf("vec%0dOutEmpty", v), 64'(bus.OUT_EMPTY), 64'(vecs[v].expOutEmpty));
      checkOutput($sformatf("vec%0dOutData", v), 64'(bus.OUT_DATA), (g == '0) ? 64'd0 : 64'(tablePattern(gi)));
      for (int k = 0; k < N_CH; k++) if (vecs[v].expChRead[k]) expCnt[k]++;
      @(posedge clock);
      #1;
    end
    checkStats("tableStats");

    // Asynchronous reset in the middle of a grant
    checkOutput("preRstGrant", 64'(bus.GRANT), 64'b0001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstGrant", 64'(bus.GRANT), 64'd0);
    checkOutput("midRstOutEmpty", 64'(bus.OUT_EMPTY), 64'd1);
    for (int k = 0; k < N_CH; k++) expCnt[k] = 0;

    // Fairness: 40 words per channel, continuous reads
    outRead  = 1'b1;
    chEnable = '1;
    for (int k = 0; k < N_CH; k++)
      for (int i = 0; i < 40; i++) chQ[k].push_back(mkWord(k, i));
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_CH; k++) begin
        n = (40 - 16*r > MAX_BURST) ? MAX_BURST : 40 - 16*r;
        expGrantQ.push_back(k);
        for (int i = 0; i < n; i++) expQ.push_back(mkWord(k, 16*r + i));
      end
    end
    driveFromModel();
    repeat (2) @(posedge clock);
    #1;
    checkStats("rstStats");
    reset    = 1'b0;
    wordsOut = 0;
    runUntilDrained("fairness", 400);
    checkOutput("fairWords", 64'(wordsOut), 64'd160);
    checkStats("fairStats");

    // Early empty: three words in channel 2 only
    for (int i = 0; i < 3; i++) chQ[2].push_back(mkWord(2, i));
    for (int i = 0; i < 3; i++) expQ.push_back(mkWord(2, i));
    expGrantQ.push_back(2);
    busyCycles   = 0;
    readCount[2] = 0;
    runUntilDrained("earlyEmpty", 50);
    repeat (5) modelCycle();
    checkOutput("earlyReads", 64'(readCount[2]), 64'd3);
    checkOutput("earlyBusyCycles", 64'(busyCycles), 64'd4);
    #4;
    checkOutput("earlyOutEmpty", 64'(bus.OUT_EMPTY), 64'd1);
    checkOutput("earlyGrant", 64'(bus.GRANT), 64'd0);
    @(posedge clock);
    #1;

    // Channel 1 disabled after five reads; channel 2 must be next
    for (int i = 0; i < 20; i++) chQ[1].push_back(mkWord(1, i));
    for (int i = 0; i < 4; i++)  chQ[2].push_back(mkWord(2, 100 + i));
    for (int i = 0; i < 5; i++)  expQ.push_back(mkWord(1, i));
    for (int i = 0; i < 4; i++)  expQ.push_back(mkWord(2, 100 + i));
    expGrantQ.push_back(1);
    expGrantQ.push_back(2);
    readCount[1] = 0;
    disableCh    = 1;
    disableAfter = 5;
    runUntilDrained("disable", 80);
    repeat (5) modelCycle();
    checkOutput("disableReads", 64'(readCount[1]), 64'd5);
    checkOutput("disabledGrant", 64'(bus.GRANT), 64'd0);
    checkStats("disableStats");
    disableCh = -1;
    chQ[1].delete();
    chEnable = '1;

`ifdef ARB_STATS_EN
    // Saturation of the channel 0 statistics counter
    begin
      int pulses = 0;
      int cyc    = 0;
      reset = 1'b1;
      applyStimulus(4'b0001, 4'b1110, 1'b1);
      repeat (2) @(posedge clock);
      #1;
      for (int k = 0; k < N_CH; k++) expCnt[k] = 0;
      checkStats("satRstStats");
      reset = 1'b0;
      while (pulses < 70000 && cyc < 80000) begin
        #4;
        if (bus.CH_READ[0]) pulses++;
        @(posedge clock);
        #1;
        cyc++;
      end
      checkOutput("satReads", 64'(pulses), 64'd70000);
      checkOutput("satCount", 64'(bus.GRANT_CNT[15:0]), 64'hFFFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
